mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported 64-bit unified memory between the instruction-fetch stage and the MEM-stage load/store path of the 5-stage RV64 pipeline. It accepts one request at a time through a req/gnt handshake, sequences the memory command and a fixed read latency, and returns a one-cycle response pulse to the winning requester. Data accesses have priority, and a starvation counter bounds how long fetch can wait.

## Interface
- `MEM_LAT`, default 2: cycles from the memory command cycle to the cycle in which `mem_rdata` is valid; legal range 1..15.
- `MAX_WAIT`, default 4: consecutive data grants allowed while `if_req` is pending before fetch is forced; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  32  fetch byte address; bit 2 selects the 32-bit half of the 64-bit word.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_rvalid`  out  1  one-cycle fetch response pulse (registered).
- `if_rdata`  out  32  instruction word; valid while `if_rvalid`=1.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address (64-bit aligned).
- `d_wdata`  in  64  store data.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rvalid`  out  1  one-cycle data completion pulse (registered), for both loads and stores.
- `d_rdata`  out  64  load data; updated only on load completion, otherwise holds its value.
- `mem_en`  out  1  memory command strobe, one cycle per transaction.
- `mem_we`  out  1  write enable, qualified by `mem_en`.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  64  memory write data.
- `mem_rdata`  in  64  memory read data.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE: if any request is present, select a winner, assert its gnt, latch address/we/wdata/source, then go to CMD. With no request, remain in IDLE.
- Arbitration in IDLE:
  - `d_req` only: data wins.
  - `if_req` only: fetch wins.
  - Both: data wins, unless `starve_cnt` == `MAX_WAIT`, in which case fetch wins.
- `starve_cnt` (4 bits):
  - Increments on a data grant while `if_req`=1.
  - Clears on any fetch grant, and on a data grant while `if_req`=0.
  - Saturates at `MAX_WAIT`.
- CMD: drive `mem_en`=1 with `mem_we`, `mem_addr` and `mem_wdata` from the latched registers. Load the latency counter with `MEM_LAT`, then go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, capture `mem_rdata` into the response register, then go to RESP.
- RESP: pulse the source's rvalid for one cycle.
  - Fetch response: `if_rdata` = captured[63:32] if latched addr[2]=1, else captured[31:0].
  - Load response: `d_rdata` = captured.
  - Store response: `d_rdata` unchanged.
  - Return to IDLE.
- At most one transaction is outstanding; gnt is never asserted outside IDLE.
- A requester may drop req before gnt; no transaction results.
- `mem_en`=0 in every state except CMD. `mem_addr`/`mem_wdata` hold their last values.

## Timing
- Grant in cycle t (IDLE). `mem_en` in cycle t+1. `mem_rdata` sampled at the end of cycle t+1+`MEM_LAT`. rvalid in cycle t+2+`MEM_LAT`. Next grant is possible at t+3+`MEM_LAT`.
- With the defaults, one transaction completes every 5 cycles.
- gnt is combinational from state, requests and `starve_cnt`; it does not depend on `mem_rdata`.
- Reset (`rst`=0, any cycle including mid-transaction): the in-flight transaction is aborted and no rvalid is issued.
  - Reset values: state=IDLE, `starve_cnt`=0, latency counter=0.
  - Outputs: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_rvalid`=0, `d_rvalid`=0, `if_rdata`=0, `d_rdata`=0, `busy`=0.
  - `if_gnt`=0 and `d_gnt`=0 while `rst`=0.
- Release of `rst` is synchronized by the design flow. The first grant is possible in the first clock edge's cycle after release.
- Requests arriving during CMD/WAIT/RESP are held off (gnt=0) and are arbitrated on return to IDLE.

## Test plan
- Single load: `d_req`=1, `d_we`=0, `d_addr`=0x40, memory word 0x1122334455667788.
  - `d_gnt` at t0, `mem_en` at t1 with `mem_addr`=0x40.
  - `d_rvalid` at t4 with `d_rdata`=0x1122334455667788; `busy`=1 for t1..t4.
- Fetch half select: `if_addr`=0x44, memory word 0xAAAAAAAA_BBBBBBBB.
  - `if_rvalid` at t4 with `if_rdata`=0xAAAAAAAA.
  - Repeating with `if_addr`=0x40 returns 0xBBBBBBBB.
- Store: `d_we`=1, `d_wdata`=0xDEADBEEF00000001, `d_addr`=0x80.
  - `mem_en`=1, `mem_we`=1 at t1 with matching address and data.
  - `d_rvalid` at t4; `d_rdata` keeps its previous value.
- Simultaneous requests: `if_req` and `d_req` both held high continuously, `MAX_WAIT`=4.
  - Grant order: D, D, D, D, I, D, D, D, D, I.
  - Grants are spaced exactly 5 cycles apart.
- Reset mid-operation: assert `rst`=0 in the WAIT cycle of a load.
  - All outputs go to their reset values immediately; no `d_rvalid` is issued.
  - After release, a new `if_req` is granted in the first cycle and completes 4 cycles later.
- Latency sweep: `MEM_LAT`=1 and `MEM_LAT`=7.
  - rvalid appears at t3 and t9 respectively.
  - `mem_rdata` is sampled at the end of cycle t+1+`MEM_LAT`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// MEM-stage load/store path; one transaction in flight, fixed read latency.
module mem_port_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [3:0]  lat_q, lat_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        src_if_q, src_if_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        fetch_wins;

    // Handshake: a requester holds req until it sees gnt; a transfer is accepted in
    // any cycle where req && gnt. gnt is only raised in IDLE and never during reset.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        lat_d       = lat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        src_if_d    = src_if_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        fetch_wins  = if_req && (!d_req || starve_q == STARVE_MAX);

        case (state_q)
            S_IDLE: begin
                if (rst && (if_req || d_req)) begin
                    state_d = S_CMD;
                    if (fetch_wins) begin
                        if_gnt   = 1'b1;
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        src_if_d = 1'b1;
                        starve_d = 4'd0;
                    end else begin
                        d_gnt    = 1'b1;
                        addr_d   = d_addr;
                        we_d     = d_we;
                        wdata_d  = d_wdata;
                        src_if_d = 1'b0;
                        // Only a data grant that overtakes a waiting fetch counts as starvation.
                        if (!if_req) begin
                            starve_d = 4'd0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            S_CMD: begin
                lat_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q <= 4'd1) begin
                    state_d = S_RESP;
                    if (src_if_q) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else begin
                        d_rvalid_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starve_q    <= 4'd0;
            lat_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 64'd0;
            we_q        <= 1'b0;
            src_if_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 64'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            src_if_q    <= src_if_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en      = (state_q == S_CMD);
    assign mem_we      = mem_en && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_rvalid   = if_rvalid_q;
    assign if_rdata    = if_rdata_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 7) behind one stimulus,
// each with its own memory that shows read data only in the exact latency cycle.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;

    logic        if_gnt_a    [3];
    logic        if_rvalid_a [3];
    logic [31:0] if_rdata_a  [3];
    logic        d_gnt_a     [3];
    logic        d_rvalid_a  [3];
    logic [63:0] d_rdata_a   [3];
    logic        mem_en_a    [3];
    logic        mem_we_a    [3];
    logic [31:0] mem_addr_a  [3];
    logic [63:0] mem_wdata_a [3];
    logic [63:0] mem_rdata_a [3];
    logic        busy_a      [3];
    logic [1:0]  dbg_state_a [3];

    int lat_of [3] = '{2, 1, 7};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(
            .MEM_LAT  (g == 0 ? 2 : (g == 1 ? 1 : 7)),
            .MAX_WAIT (4)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .if_req      (if_req),
            .if_addr     (if_addr),
            .if_gnt      (if_gnt_a[g]),
            .if_rvalid   (if_rvalid_a[g]),
            .if_rdata    (if_rdata_a[g]),
            .d_req       (d_req),
            .d_we        (d_we),
            .d_addr      (d_addr),
            .d_wdata     (d_wdata),
            .d_gnt       (d_gnt_a[g]),
            .d_rvalid    (d_rvalid_a[g]),
            .d_rdata     (d_rdata_a[g]),
            .mem_en      (mem_en_a[g]),
            .mem_we      (mem_we_a[g]),
            .mem_addr    (mem_addr_a[g]),
            .mem_wdata   (mem_wdata_a[g]),
            .mem_rdata   (mem_rdata_a[g]),
            .busy        (busy_a[g]),
            .dbg_state_o (dbg_state_a[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory models ----------------
    logic [63:0] mem_arr [3][128];
    logic [63:0] rd_hold [3];
    int          rd_cnt  [3] = '{0, 0, 0};

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                rd_cnt[k] = 0;
            end else begin
                if (rd_cnt[k] > 0) rd_cnt[k]--;
                if (mem_en_a[k]) begin
                    if (mem_we_a[k]) mem_arr[k][mem_addr_a[k][9:3]] = mem_wdata_a[k];
                    rd_hold[k] = mem_arr[k][mem_addr_a[k][9:3]];
                    rd_cnt[k]  = lat_of[k] + 1;
                end
            end
            mem_rdata_a[k] = (rd_cnt[k] == 1) ? rd_hold[k] : {$urandom, $urandom};
        end
    end

    // ---------------- scoreboard ----------------
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst    = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string       name;
        bit          is_if;
        bit          we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    logic [97:0] exp_q [$];
    logic [63:0] shadow [128];

    initial begin
        int          n_gnt;
        int          c;
        bit          ord  [10];
        int          gcyc [10];
        bit          exp_ord [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int          cyc, next_free, last_gnt, starve;
        bit          win_if, win_d, exp_ir, exp_dr, if_gnt_prev, d_gnt_prev, stop_new;
        logic [31:0] exp_if_rdata;
        logic [63:0] exp_d_rdata, data;
        logic [97:0] e;
        logic [6:0]  idx;

        vecs[0] = '{"load40",   1'b0, 1'b0, 32'h40,  64'h0,                   64'h1122334455667788};
        vecs[1] = '{"fetch_hi", 1'b1, 1'b0, 32'h104, 64'h0,                   64'h00000000AAAAAAAA};
        vecs[2] = '{"fetch_lo", 1'b1, 1'b0, 32'h100, 64'h0,                   64'h00000000BBBBBBBB};
        vecs[3] = '{"store80",  1'b0, 1'b1, 32'h80,  64'hDEADBEEF00000001,    64'h1122334455667788};
        vecs[4] = '{"load80",   1'b0, 1'b0, 32'h80,  64'h0,                   64'hDEADBEEF00000001};
        vecs[5] = '{"fetch_st", 1'b1, 1'b0, 32'h84,  64'h0,                   64'h00000000DEADBEEF};

        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 128; w++) mem_arr[k][w] = {$urandom, $urandom};
            mem_arr[k][8]  = 64'h1122334455667788;
            mem_arr[k][32] = 64'hAAAAAAAA_BBBBBBBB;
            mem_arr[k][16] = 64'h0;
        end

        rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 64'h0;
        step(); step(); #4;
        chk("rst_if_gnt",   64'(if_gnt_a[0]), 64'd0);
        chk("rst_d_gnt",    64'(d_gnt_a[0]),  64'd0);
        chk("rst_mem_en",   64'(mem_en_a[0]), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_a[0]), 64'd0);
        chk("rst_busy",     64'(busy_a[0]),   64'd0);
        chk("rst_d_rdata",  d_rdata_a[0],     64'd0);
        step();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;

        // ---- table of single transactions ----
        for (int v = 0; v < 6; v++) begin
            step();
            if_req  = vecs[v].is_if;
            d_req   = !vecs[v].is_if;
            if_addr = vecs[v].addr;
            d_addr  = vecs[v].addr;
            d_we    = vecs[v].we;
            d_wdata = vecs[v].wdata;
            #4;
            chk({vecs[v].name, "_if_gnt"}, 64'(if_gnt_a[0]), 64'(vecs[v].is_if));
            chk({vecs[v].name, "_d_gnt"},  64'(d_gnt_a[0]),  64'(!vecs[v].is_if));
            step();
            if_req = 1'b0; d_req = 1'b0;
            #4;
            chk({vecs[v].name, "_mem_en"},   64'(mem_en_a[0]),   64'd1);
            chk({vecs[v].name, "_mem_we"},   64'(mem_we_a[0]),   64'(vecs[v].we));
            chk({vecs[v].name, "_mem_addr"}, 64'(mem_addr_a[0]), 64'(vecs[v].addr));
            if (vecs[v].we) chk({vecs[v].name, "_mem_wdata"}, mem_wdata_a[0], vecs[v].wdata);
            chk({vecs[v].name, "_busy1"}, 64'(busy_a[0]), 64'd1);
            for (int t = 2; t <= 4; t++) begin
                step(); #4;
                chk({vecs[v].name, "_busy"},   64'(busy_a[0]),   64'd1);
                chk({vecs[v].name, "_mem_en0"}, 64'(mem_en_a[0]), 64'd0);
                chk({vecs[v].name, "_if_rv"}, 64'(if_rvalid_a[0]), 64'(t == 4 && vecs[v].is_if));
                chk({vecs[v].name, "_d_rv"},  64'(d_rvalid_a[0]),  64'(t == 4 && !vecs[v].is_if));
            end
            if (vecs[v].is_if) chk({vecs[v].name, "_if_rdata"}, 64'(if_rdata_a[0]), vecs[v].exp);
            else               chk({vecs[v].name, "_d_rdata"},  d_rdata_a[0],        vecs[v].exp);
            step(); #4;
            chk({vecs[v].name, "_idle"}, 64'(busy_a[0]), 64'd0);
        end

        // ---- both requesters held high: starvation bound ----
        do_reset();
        n_gnt = 0; c = 0;
        while (n_gnt < 10 && c < 80) begin
            step(); c++;
            if (c == 1) begin
                if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
                if_addr = 32'h104; d_addr = 32'h40;
            end
            #4;
            if (if_gnt_a[0] || d_gnt_a[0]) begin
                ord[n_gnt]  = if_gnt_a[0];
                gcyc[n_gnt] = c;
                n_gnt++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("arb_count", 64'(n_gnt), 64'd10);
        for (int i = 0; i < n_gnt; i++) begin
            chk($sformatf("arb_order%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
            if (i > 0) chk($sformatf("arb_space%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd5);
        end

        // ---- reset during the WAIT cycle of a load ----
        for (int i = 0; i < 12; i++) step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        #4;
        chk("rmid_d_gnt", 64'(d_gnt_a[0]), 64'd1);
        step();
        d_req = 1'b0;
        step();
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h104;
        #4;
        chk("rmid_mem_en",    64'(mem_en_a[0]),    64'd0);
        chk("rmid_mem_we",    64'(mem_we_a[0]),    64'd0);
        chk("rmid_mem_addr",  64'(mem_addr_a[0]),  64'd0);
        chk("rmid_mem_wdata", mem_wdata_a[0],      64'd0);
        chk("rmid_if_rv",     64'(if_rvalid_a[0]), 64'd0);
        chk("rmid_d_rv",      64'(d_rvalid_a[0]),  64'd0);
        chk("rmid_if_rdata",  64'(if_rdata_a[0]),  64'd0);
        chk("rmid_d_rdata",   d_rdata_a[0],        64'd0);
        chk("rmid_busy",      64'(busy_a[0]),      64'd0);
        chk("rmid_if_gnt",    64'(if_gnt_a[0]),    64'd0);
        chk("rmid_d_gnt0",    64'(d_gnt_a[0]),     64'd0);
        step();
        step();
        rst = 1'b1;
        #4;
        chk("rrel_if_gnt", 64'(if_gnt_a[0]), 64'd1);
        for (int t = 1; t <= 5; t++) begin
            step();
            if (t == 1) if_req = 1'b0;
            #4;
            chk("rrel_d_rv",  64'(d_rvalid_a[0]),  64'd0);
            chk("rrel_if_rv", 64'(if_rvalid_a[0]), 64'(t == 4));
            if (t == 4) chk("rrel_if_rdata", 64'(if_rdata_a[0]), 64'hAAAAAAAA);
        end

        // ---- latency sweep across the three instances ----
        do_reset();
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        #4;
        for (int k = 0; k < 3; k++) chk($sformatf("lat%0d_gnt", lat_of[k]), 64'(d_gnt_a[k]), 64'd1);
        for (int t = 1; t <= 10; t++) begin
            step();
            if (t == 1) d_req = 1'b0;
            #4;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("lat%0d_mem_en_t%0d", lat_of[k], t), 64'(mem_en_a[k]), 64'(t == 1));
                chk($sformatf("lat%0d_d_rv_t%0d", lat_of[k], t), 64'(d_rvalid_a[k]), 64'(t == lat_of[k] + 2));
                if (t == lat_of[k] + 2)
                    chk($sformatf("lat%0d_d_rdata", lat_of[k]), d_rdata_a[k], 64'h1122334455667788);
            end
        end

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        for (int w = 0; w < 128; w++) shadow[w] = mem_arr[0][w];
        cyc = 0; next_free = 0; last_gnt = -10; starve = 0;
        exp_if_rdata = 32'd0; exp_d_rdata = 64'd0;
        if_gnt_prev = 1'b0; d_gnt_prev = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            step();
            cyc++;
            stop_new = (n >= 1485);
            if (if_req && if_gnt_prev) if_req = 1'b0;
            if (d_req && d_gnt_prev)   d_req  = 1'b0;
            if (stop_new) begin
                if_req = 1'b0; d_req = 1'b0;
            end else begin
                if (!if_req) begin
                    if ($urandom_range(0, 2) == 0) begin
                        if_req  = 1'b1;
                        if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    if_req = 1'b0;
                end
                if (!d_req) begin
                    if ($urandom_range(0, 1) == 0) begin
                        d_req   = 1'b1;
                        d_we    = 1'($urandom_range(0, 1));
                        d_addr  = {22'd0, 7'($urandom_range(0, 127)), 3'b000};
                        d_wdata = {$urandom, $urandom};
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    d_req = 1'b0;
                end
            end
            #4;

            exp_ir = 1'b0; exp_dr = 1'b0;
            if (exp_q.size() > 0 && int'(exp_q[0][95:64]) == cyc) begin
                e = exp_q.pop_front();
                if (e[97]) begin
                    exp_ir = 1'b1;
                    exp_if_rdata = e[31:0];
                end else begin
                    exp_dr = 1'b1;
                    if (!e[96]) exp_d_rdata = e[63:0];
                end
            end
            chk("rnd_if_rvalid", 64'(if_rvalid_a[0]), 64'(exp_ir));
            chk("rnd_d_rvalid",  64'(d_rvalid_a[0]),  64'(exp_dr));
            chk("rnd_if_rdata",  64'(if_rdata_a[0]),  64'(exp_if_rdata));
            chk("rnd_d_rdata",   d_rdata_a[0],        exp_d_rdata);
            chk("rnd_busy",      64'(busy_a[0]),      64'(cyc < next_free));
            chk("rnd_mem_en",    64'(mem_en_a[0]),    64'(cyc == last_gnt + 1));

            win_if = 1'b0; win_d = 1'b0;
            if (cyc >= next_free && (if_req || d_req)) begin
                if (if_req && (!d_req || starve == 4)) win_if = 1'b1;
                else win_d = 1'b1;
            end
            chk("rnd_if_gnt", 64'(if_gnt_a[0]), 64'(win_if));
            chk("rnd_d_gnt",  64'(d_gnt_a[0]),  64'(win_d));
            if (win_if) begin
                idx  = if_addr[9:3];
                data = {32'd0, (if_addr[2] ? shadow[idx][63:32] : shadow[idx][31:0])};
                exp_q.push_back({1'b1, 1'b0, 32'(cyc + 4), data});
                starve = 0;
            end else if (win_d) begin
                idx = d_addr[9:3];
                if (d_we) shadow[idx] = d_wdata;
                exp_q.push_back({1'b0, d_we, 32'(cyc + 4), shadow[idx]});
                starve = if_req ? ((starve < 4) ? starve + 1 : 4) : 0;
            end
            if (win_if || win_d) begin
                last_gnt  = cyc;
                next_free = cyc + 5;
            end
            if_gnt_prev = if_gnt_a[0];
            d_gnt_prev  = d_gnt_a[0];
        end
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
